// File: rtl/ofm_accum_pool_if.sv
// Stream bundle between the conv MAC, the accumulate/pool stage and the output writer.
interface ofm_accum_pool_if #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 15,
  parameter int LVL_W = 3
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_ready;
  logic             overflow;
  logic [LVL_W-1:0] level;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, overflow, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, overflow, level
  );
endinterface

// File: rtl/ofm_accum_pool.sv
// Sums ACC_LEN partial sums per pixel, max-pools POOL_LEN pixels and queues
// the pooled results in a small FIFO drained over valid/ready.
module ofm_accum_pool #(
  parameter int IN_W       = 13,
  parameter int ACC_LEN    = 4,
  parameter int POOL_LEN   = 2,
  parameter int OUT_W      = IN_W + $clog2(ACC_LEN),
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  ofm_accum_pool_if.slave bus
);
  localparam int ACC_CW  = (ACC_LEN  > 1) ? $clog2(ACC_LEN)  : 1;
  localparam int POOL_CW = (POOL_LEN > 1) ? $clog2(POOL_LEN) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;

  function automatic logic [OUT_W-1:0] max_u(input logic [OUT_W-1:0] a,
                                             input logic [OUT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [ACC_CW-1:0]  acc_cnt_q,  acc_cnt_d;
  logic [POOL_CW-1:0] pool_cnt_q, pool_cnt_d;
  logic [OUT_W-1:0]   acc_q,      acc_d;
  logic [OUT_W-1:0]   max_q,      max_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [LVL_W-1:0]   count_q,    count_d;
  logic               ovf_q,      ovf_d;
  logic [OUT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0]   mem_d [FIFO_DEPTH];

  logic             acc_last, pool_last, full, pop, push, push_ok;
  logic [OUT_W-1:0] sum, pooled;

  assign acc_last  = (acc_cnt_q == ACC_CW'(ACC_LEN - 1));
  assign pool_last = (pool_cnt_q == POOL_CW'(POOL_LEN - 1));
  assign full      = (count_q == LVL_W'(FIFO_DEPTH));
  // The first partial of a pixel restarts the sum instead of adding to stale acc.
  assign sum       = ((acc_cnt_q == '0) ? '0 : acc_q) + OUT_W'(bus.in_data);
  assign pooled    = (pool_cnt_q == '0) ? sum : max_u(sum, max_q);
  assign pop       = bus.out_valid && bus.out_ready;
  assign push      = bus.in_valid && acc_last && pool_last;
  // A full FIFO still takes the result when its head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    pool_cnt_d = pool_cnt_q;
    acc_d      = acc_q;
    max_d      = max_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    mem_d      = mem_q;
    if (clear) begin
      acc_cnt_d  = '0;
      pool_cnt_d = '0;
      acc_d      = '0;
      max_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
    end else begin
      if (bus.in_valid) begin
        acc_d     = sum;
        acc_cnt_d = acc_last ? '0 : acc_cnt_q + ACC_CW'(1);
        if (acc_last) begin
          max_d      = pooled;
          pool_cnt_d = pool_last ? '0 : pool_cnt_q + POOL_CW'(1);
        end
      end
      if (push_ok) begin
        mem_d[wr_ptr_q] = pooled;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (push && !push_ok) ovf_d = 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + LVL_W'(push_ok) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q  <= '0;
      pool_cnt_q <= '0;
      acc_q      <= '0;
      max_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      pool_cnt_q <= pool_cnt_d;
      acc_q      <= acc_d;
      max_q      <= max_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.overflow  = ovf_q;
  assign bus.level     = count_q;
endmodule

// File: tb/tb_ofm_accum_pool.sv
// Directed bench for ofm_accum_pool: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_ofm_accum_pool;
  localparam int IN_W     = 13;
  localparam int ACC_LEN  = 4;
  localparam int POOL_LEN = 2;
  localparam int OUT_W    = 15;
  localparam int DEPTH    = 4;
  localparam int LVL_W    = 3;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  ofm_accum_pool_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LVL_W(LVL_W)) bus ();

  ofm_accum_pool #(
    .IN_W(IN_W), .ACC_LEN(ACC_LEN), .POOL_LEN(POOL_LEN),
    .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: partial sums, pixel sums and results as plain queues.
  int parts[$];
  int pix[$];
  int mfifo[$];
  bit movf;
  int m_s, m_r;
  bit m_res;

  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      parts.delete();
      pix.delete();
      mfifo.delete();
      movf = 1'b0;
    end else begin
      m_res = 1'b0;
      if (bus.in_valid) begin
        parts.push_back(int'(bus.in_data));
        if (parts.size() == ACC_LEN) begin
          m_s = 0;
          foreach (parts[i]) m_s += parts[i];
          parts.delete();
          pix.push_back(m_s);
          if (pix.size() == POOL_LEN) begin
            m_r = 0;
            foreach (pix[i]) if (pix[i] > m_r) m_r = pix[i];
            pix.delete();
            m_res = 1'b1;
          end
        end
      end
      if (mfifo.size() != 0 && bus.out_ready) void'(mfifo.pop_front());
      if (m_res) begin
        if (mfifo.size() < DEPTH) mfifo.push_back(m_r);
        else movf = 1'b1;
      end
    end
  end

  int popped[$];

  always @(negedge clk) begin
    chk("out_valid", int'(bus.out_valid), int'(mfifo.size() != 0));
    chk("level", int'(bus.level), mfifo.size());
    chk("overflow", int'(bus.overflow), int'(movf));
    if (mfifo.size() != 0) chk("out_data", int'(bus.out_data), mfifo[0]);
    if (bus.out_valid && bus.out_ready) popped.push_back(int'(bus.out_data));
  end

  task automatic apply(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 13'h1FFF;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic group(input int v);
    for (int i = 0; i < ACC_LEN * POOL_LEN; i++) apply(v);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int basic[8] = '{10, 20, 30, 40, 5, 5, 5, 5};
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_level", int'(bus.level), 0);

    // Basic back-to-back group
    foreach (basic[i]) apply(basic[i]);
    chk("basic_valid", int'(bus.out_valid), 1);
    chk("basic_data", int'(bus.out_data), 100);
    idle(1);
    chk("basic_valid_drop", int'(bus.out_valid), 0);
    chk("basic_level0", int'(bus.level), 0);

    // Max in second pixel, needs 15 bits
    for (int i = 0; i < 4; i++) apply(1);
    for (int i = 0; i < 4; i++) apply(7200);
    chk("poolmax_data", int'(bus.out_data), 28800);
    idle(2);

    // Gapped input, data garbage while invalid
    foreach (basic[i]) begin
      apply(basic[i]);
      if (i != 7) idle(3);
    end
    chk("gapped_valid", int'(bus.out_valid), 1);
    chk("gapped_data", int'(bus.out_data), 100);
    idle(2);

    // Backpressure and overflow
    bus.out_ready = 1'b0;
    for (int g = 0; g < 5; g++) group(1);
    chk("bp_level", int'(bus.level), 4);
    chk("bp_overflow", int'(bus.overflow), 1);
    idle(2);
    popped.delete();
    bus.out_ready = 1'b1;
    idle(6);
    chk("bp_pops", popped.size(), 4);
    foreach (popped[i]) chk("bp_pop_val", popped[i], 4);
    chk("bp_ovf_sticky", int'(bus.overflow), 1);
    pulse_clear();
    chk("clear_ovf", int'(bus.overflow), 0);

    // Full FIFO with simultaneous pop on the completing edge
    bus.out_ready = 1'b0;
    for (int g = 0; g < 4; g++) group(1);
    chk("full_level", int'(bus.level), 4);
    for (int i = 0; i < 7; i++) apply(2);
    bus.out_ready = 1'b1;
    apply(2);
    bus.out_ready = 1'b0;
    chk("fullpop_ovf", int'(bus.overflow), 0);
    chk("fullpop_level", int'(bus.level), 4);
    popped.delete();
    bus.out_ready = 1'b1;
    idle(5);
    chk("fullpop_drained", popped.size(), 4);
    if (popped.size() == 4) chk("fullpop_last", popped[3], 8);

    // clear together with in_valid discards that sample
    apply(9); apply(9); apply(9);
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(1000);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    apply(1); apply(2); apply(3); apply(4);
    for (int i = 0; i < 4; i++) apply(10);
    chk("clear_data", int'(bus.out_data), 40);
    chk("clear_valid", int'(bus.out_valid), 1);
    idle(2);

    // Async reset mid-drain and mid-group
    bus.out_ready = 1'b0;
    for (int g = 0; g < 3; g++) group(2);
    apply(500); apply(500); apply(500);
    chk("pre_rst_level", int'(bus.level), 3);
    bus.out_ready = 1'b1;
    idle(1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_level", int'(bus.level), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) apply(3);
    for (int i = 0; i < 4; i++) apply(6);
    chk("post_rst_data", int'(bus.out_data), 24);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ofm_accum_pool.md
# ofm_accum_pool

Downstream stage of the 32-lane convolution MAC. Consumes its 13-bit `Out_OFM`/`out_valid` stream and sums ACC_LEN consecutive partial sums (channel groups) into one output-pixel value. It then max-pools POOL_LEN consecutive pixel values. Results are buffered in a small FIFO and drained over a valid/ready interface to the output writer.

## Interface
- IN_W, 13: width of incoming partial sum.
- ACC_LEN, 4: partial sums per output pixel (≥1, power of 2).
- POOL_LEN, 2: pixel values per pooled result (≥1).
- OUT_W, IN_W+log2(ACC_LEN) = 15: accumulator/output width.
- FIFO_DEPTH, 4: output FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- in_valid  in  1  partial sum valid; driven by convolution `out_valid`.
- in_data  in  IN_W  partial sum, unsigned; ignored when in_valid=0.
- clear  in  1  synchronous flush of all state except reset-only items (none).
- out_valid  out  1  FIFO head valid.
- out_data  out  OUT_W  FIFO head value, unsigned.
- out_ready  in  1  consumer accepts head this cycle.
- overflow  out  1  sticky: a pooled result was dropped because the FIFO was full.
- level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Accumulator: `acc_cnt` counts 0..ACC_LEN-1 on each sampled in_valid.
  - At acc_cnt=0: acc <= in_data.
  - Otherwise: acc <= acc+in_data.
  - At ACC_LEN-1: pixel sum S = acc+in_data goes to the pool stage and acc_cnt wraps to 0.
  - Zero-extend to OUT_W; no saturation is needed (width covers the worst case).
- Pool: `pool_cnt` counts 0..POOL_LEN-1 per pixel sum S.
  - At pool_cnt=0: max <= S.
  - Otherwise: max <= (S>max) ? S : max.
  - At POOL_LEN-1: result R = larger of max and S is pushed to the FIFO and pool_cnt wraps. Ties keep the value (same result either way).
- FIFO: circular buffer with wr_ptr, rd_ptr and count.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle both happen; count is unchanged.
  - Push while full with a pop in the same cycle: accepted.
  - Push while full without a pop: R is dropped, overflow <= 1, pointers unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- out_data is the FIFO head (rd_ptr entry). It must be held stable while out_valid=1 and out_ready=0.
- clear (priority over in_valid and out_ready in the same cycle): acc_cnt, pool_cnt, acc, max, FIFO pointers/count and overflow all go to 0; an in_valid in that cycle is discarded.
- No input backpressure exists (the upstream pipeline cannot stall); loss is signalled only via overflow.

## Timing
- Reset values: out_valid=0, out_data=0, overflow=0, level=0; all internal counters and registers are 0.
- Latency: the in_valid sample completing a pool group pushes at that edge. out_valid=1 the next cycle if the FIFO was empty.
  - Total from convolution input capture to out_valid: 3 (conv) + 1.
- in_valid may be asserted every cycle; throughput is one partial sum per clock.
- level reflects post-edge occupancy; it updates in the cycle after a push/pop.
- overflow stays 1 until rst or clear.
- Async rst mid-group: all partial accumulation is lost; the first in_valid after release starts a new group at acc_cnt=0.
- clear deasserted: the next in_valid is partial 0 of pixel 0 of pool group 0.

## Test plan
- Basic: ACC_LEN=4, POOL_LEN=2, out_ready=1. Input 10,20,30,40,5,5,5,5 on consecutive cycles -> exactly one out_valid pulse with out_data=100, one cycle after the 8th input; level returns to 0.
- Pool max second: inputs 1,1,1,1 then 7200,7200,7200,7200 -> out_data=28800, which needs 15 bits (no truncation).
- Gapped input: same as basic with in_valid low for 3 cycles between each sample and in_data=0x1FFF while low -> out_data=100 (data ignored while invalid).
- Backpressure/overflow: out_ready=0, feed 5 groups each of all-ones (each result 4) -> level=4, overflow=1 after the 5th group. Then raise out_ready -> exactly 4 pops of 4, out_data stable while stalled.
- Full with simultaneous pop: FIFO full, out_ready=1 in the cycle the 5th group completes -> no drop, overflow=0, level stays 4.
- clear and reset: clear after 3 partials (same cycle as in_valid) -> that input discarded, next 8 inputs yield a fresh correct result. Async rst mid-FIFO-drain -> out_valid=0, level=0 immediately.
